// File: rtl/serial_adder_seq.sv
// Bit-serial unsigned adder. Operands are captured on start and added one bit per
// clock, LSB first. Each sum bit is streamed on bit_out/bit_valid, and the full
// WIDTH+1-bit result is loaded into sum on the final bit, with a one-cycle done pulse.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             bit_out,
  output logic             bit_valid
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;

  logic             s_bit;
  logic             c_next;

  // Full-adder slice on the current operand LSBs and the running carry.
  always_comb begin
    s_bit  = a_q[0] ^ b_q[0] ^ c_q;
    c_next = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    sum_d       = sum_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        a_d         = a_q >> 1;
        b_d         = b_q >> 1;
        c_d         = c_next;
        // Result fills from the top so bit 0 lands in place after WIDTH shifts.
        res_d       = {s_bit, res_q[WIDTH-1:1]};
        cnt_d       = cnt_q + CntW'(1);
        bit_out_d   = s_bit;
        bit_valid_d = 1'b1;
        if (cnt_q == LastCnt) begin
          sum_d   = {c_next, s_bit, res_q[WIDTH-1:1]};
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    sum       = sum_q;
    bit_out   = bit_out_q;
    bit_valid = bit_valid_q;
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: table vectors, random operations against a plain
// arithmetic reference, and hand sequences for start-during-run and reset abort.
module tb_serial_adder_seq;

  localparam int W = 8;
  localparam int N = W + 3;  // observation window: acceptance edge plus W+2 edges

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W:0]   sum;
  logic         bit_out;
  logic         bit_valid;

  int           n_tests = 0;
  int           n_fail = 0;
  logic [W:0]   model_sum;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
  } vec_t;

  vec_t vecs[6];

  serial_adder_seq #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .bit_out  (bit_out),
    .bit_valid(bit_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; returns #1 after the acceptance edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observe one operation from its acceptance edge (k=0) to k=N-1. Operands are
  // scrambled while running; optionally a start is pulsed mid-run and/or held from
  // late in the run so the next operation is accepted on the first IDLE edge.
  task automatic monitor(input logic [W:0] exp_sum, input bit mid_start, input bit hold_start,
                         input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [N-1:0] v_valid, v_done, v_busy, v_bits;
    logic [N-1:0] e_valid, e_done, e_busy, e_bits;
    int sum_bad;
    sum_bad = 0;
    for (int k = 0; k < N; k++) begin
      v_valid[k] = bit_valid;
      v_done[k]  = done;
      v_busy[k]  = busy;
      v_bits[k]  = bit_out;
      if (k < W) begin
        if (sum !== model_sum) sum_bad++;
      end else begin
        if (sum !== exp_sum) sum_bad++;
      end
      if (k < N - 1) begin
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        start = mid_start && (k == 3);
        if (hold_start && k >= W - 1) begin
          start = 1'b1;
          a_in  = na;
          b_in  = nb;
        end
        tick();
      end
    end
    for (int k = 0; k < N; k++) begin
      e_valid[k] = (k >= 1) && (k <= W);
      e_done[k]  = (k == W);
      e_busy[k]  = (k < W) || (hold_start && k == N - 1);
      e_bits[k]  = 1'b0;
      if (k >= 1 && k <= W) e_bits[k] = exp_sum[k-1];
    end
    check("bit_valid window", 32'(v_valid), 32'(e_valid));
    check("done pulse", 32'(v_done), 32'(e_done));
    check("busy window", 32'(v_busy), 32'(e_busy));
    check("bit stream", 32'(v_bits), 32'(e_bits));
    check("sum held then updated", sum_bad, 0);
    check("final sum", 32'(sum), 32'(exp_sum));
    model_sum = exp_sum;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   rexp;
    int           done_seen;

    vecs[0] = '{a: 8'h01, b: 8'h01, exp: 9'h002};
    vecs[1] = '{a: 8'hFF, b: 8'h01, exp: 9'h100};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, exp: 9'h1FE};
    vecs[3] = '{a: 8'h00, b: 8'h00, exp: 9'h000};
    vecs[4] = '{a: 8'hAA, b: 8'h55, exp: 9'h0FF};
    vecs[5] = '{a: 8'h80, b: 8'h80, exp: 9'h100};

    // Reset for two cycles with start high: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'h12;
    b_in  = 8'h34;
    tick();
    tick();
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset bit_valid", 32'(bit_valid), 0);
    check("reset bit_out", 32'(bit_out), 0);
    check("reset sum", 32'(sum), 0);
    rst       = 1'b0;
    start     = 1'b0;
    model_sum = '0;
    tick();
    check("idle without start", 32'(busy), 0);

    // Table vectors.
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      monitor(vecs[i].exp, 1'b0, 1'b0, '0, '0);
    end

    // Start pulsed mid-run plus start held through DONE into the next operation.
    launch(8'h35, 8'h4C);
    monitor(9'h081, 1'b1, 1'b1, 8'hC3, 8'h7E);
    start = 1'b0;
    monitor(9'h141, 1'b0, 1'b0, '0, '0);

    // Reset after four RUN cycles aborts the operation.
    launch(8'h0F, 8'hF0);
    repeat (4) tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort bit_valid", 32'(bit_valid), 0);
    check("abort sum", 32'(sum), 0);
    rst       = 1'b0;
    start     = 1'b0;
    model_sum = '0;
    done_seen = 0;
    for (int k = 0; k < N; k++) begin
      if (done || busy) done_seen++;
      tick();
    end
    check("no activity after abort", done_seen, 0);
    launch(8'h9C, 8'h27);
    monitor(9'h0C3, 1'b0, 1'b0, '0, '0);

    // Random operations against plain addition.
    for (int i = 0; i < 16; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb};
      launch(ra, rb);
      monitor(rexp, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand width in bits (legal range 2..16).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port start, input, 1 bit: request to add the operands presented on a_in and b_in.
REQ-005 Port a_in, input, WIDTH bits: operand A, sampled only when a start is accepted.
REQ-006 Port b_in, input, WIDTH bits: operand B, sampled only when a start is accepted.
REQ-007 Port busy, output, 1 bit: high while an addition is in progress (RUN state).
REQ-008 Port done, output, 1 bit: one-cycle pulse indicating that sum holds a new result.
REQ-009 Port sum, output, WIDTH+1 bits: registered result; bit WIDTH is the final carry.
REQ-010 Port bit_out, output, 1 bit: serial sum bit, LSB first, for the downstream stage.
REQ-011 Port bit_valid, output, 1 bit: qualifies bit_out.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1: on that edge, capture a_in and b_in into shift registers, clear the carry flop and the bit counter, and go to RUN.
REQ-014 IDLE with start=0: remain in IDLE with no state change.
REQ-015 RUN, each edge: compute s = a0 ^ b0 ^ c and c_next = (a0 & b0) | (c & (a0 ^ b0)) from the operand LSBs a0, b0 and carry c.
REQ-016 RUN, each edge (continued): shift both operands right by one, shift s into the internal result register, and increment the counter.
REQ-017 RUN, each edge SHALL also register bit_out <= s and bit_valid <= 1; in every other state bit_valid <= 0 and bit_out <= 0.
REQ-018 On the RUN edge that processes bit WIDTH-1: load sum with {c_next, result bits} and go to DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency: if start is accepted at edge N, then bit_valid=1 for the cycles following edges N+1..N+WIDTH, and done=1 only in the cycle following edge N+WIDTH.
REQ-021 busy SHALL be 1 exactly while the state is RUN.
REQ-022 sum SHALL hold its previous value throughout RUN and change only on the completion edge.
REQ-023 start SHALL be ignored in RUN and in DONE; a start held high through DONE is accepted on the first IDLE edge.
REQ-024 Operand changes on a_in and b_in after acceptance SHALL NOT affect the result in progress.
REQ-025 Arithmetic is unsigned; the full WIDTH+1-bit sum SHALL never overflow or wrap.

Reset
REQ-026 rst=1 at an edge SHALL force the IDLE state, and clear busy, done, bit_out, bit_valid, sum, the carry, the counter and the shift registers, regardless of the current state.
REQ-027 rst SHALL take priority over start on the same edge.
REQ-028 Reset during RUN SHALL abort the operation: no done pulse, and sum = 0.

Verification (WIDTH=8)
REQ-029 Reset: assert rst for 2 cycles -> busy=0, done=0, bit_valid=0, sum=0x000, state IDLE.
REQ-030 a_in=0x01, b_in=0x01, start at edge N -> busy=1 over edges N..N+7, done pulses after edge N+8, sum=0x002.
REQ-031 a_in=0xFF, b_in=0x01 -> sum=0x100, bit stream 0,0,0,0,0,0,0,0, sum[8]=1.
REQ-032 a_in=0xFF, b_in=0xFF -> sum=0x1FE; bit_out LSB-first is 0,1,1,1,1,1,1,1, with bit_valid high for exactly 8 cycles.
REQ-033 Start pulsed mid-RUN with new operands, and start held through DONE -> first result unchanged; the second operation begins on the edge after DONE.
REQ-034 rst asserted after 4 RUN cycles -> busy=0 next cycle, no done pulse ever, sum=0x000, and a new start is accepted afterwards normally.
